// File: rtl/value_ctrl_pkg.sv
// Shared types and constants for the value bank sequencer.
// Holds the FSM state enum and the lane geometry of the PE array.
package value_ctrl_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int STEP_W_DEF = 15;
    localparam int LANES      = 32;
    localparam int LOG2_LANES = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_REQ,
        ST_INIT_WAIT,
        ST_LEAF,
        ST_STEP,
        ST_DRAIN,
        ST_FIN
    } state_e;

endpackage

// File: rtl/value_ctrl_pipe.sv
// Delay line carrying {valid, keep, addr} from read issue to write-back.
// Ports: in_* push each cycle, out_* is the exiting slot, empty flags no entry behind it.
module value_ctrl_pipe #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    input  logic              in_keep,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic              out_keep,
    output logic [ADDR_W-1:0] out_addr,
    output logic              empty
);

    logic [DEPTH-1:0]  vld_q;
    logic [DEPTH-1:0]  vld_d;
    logic [DEPTH-1:0]  keep_q;
    logic [DEPTH-1:0]  keep_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];

    always_comb begin
        vld_d     = {vld_q[DEPTH-2:0], in_valid};
        keep_d    = {keep_q[DEPTH-2:0], in_keep};
        addr_d[0] = in_addr;
        for (int i = 1; i < DEPTH; i++) begin
            addr_d[i] = addr_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_q  <= '0;
            keep_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            keep_q <= keep_d;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_keep  = keep_q[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];
    // Ignores the exit slot: once this is set the pipe is empty next
    // cycle, so the next step's first read lands right after the last write.
    assign empty     = ~|vld_q[DEPTH-2:0];

endmodule

// File: rtl/value_membank_ctrl.sv
// Sequencer for the value bank: init, leaf writes, backward tree walk.
// Ports: start/num_steps in, init handshake, bank rd/wr addressing, PE strobes, busy/done.
module value_membank_ctrl
    import value_ctrl_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int STEP_W   = STEP_W_DEF,
    parameter int PIPE_LAT = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    output logic              init_start,
    input  logic              init_done,
    output logic [ADDR_W-1:0] rdaddr,
    output logic [ADDR_W-1:0] wraddr,
    output logic              wren,
    output logic              leaf_phase,
    output logic              pe_valid,
    output logic              pe_first,
    output logic [STEP_W-1:0] step_idx,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [STEP_W-1:0] n_q, n_d;
    logic [STEP_W-1:0] s_q, s_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pe_valid_q, pe_valid_d;
    logic              pe_first_q, pe_first_d;

    logic              push;
    logic              keep;
    logic [STEP_W-1:0] s_inc;
    logic [ADDR_W-1:0] top_addr;
    logic [ADDR_W-1:0] last_wr;
    logic [ADDR_W-1:0] leaf_last;
    logic              out_valid;
    logic              out_keep;
    logic [ADDR_W-1:0] out_addr;
    logic              pipe_empty;

    assign s_inc     = s_q + STEP_W'(1);
    assign top_addr  = ADDR_W'(s_inc >> LOG2_LANES);
    assign last_wr   = ADDR_W'(s_q >> LOG2_LANES);
    assign leaf_last = ADDR_W'(n_q >> LOG2_LANES);
    assign push      = (state_q == ST_STEP);
    // The top read only feeds the lane-0 neighbour when the word count
    // shrinks; it carries keep=0 and its write-back is dropped.
    assign keep      = (addr_q <= last_wr);

    value_ctrl_pipe #(
        .ADDR_W (ADDR_W),
        .DEPTH  (PIPE_LAT)
    ) u_pipe (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (push),
        .in_keep   (keep),
        .in_addr   (addr_q),
        .out_valid (out_valid),
        .out_keep  (out_keep),
        .out_addr  (out_addr),
        .empty     (pipe_empty)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        s_d        = s_q;
        addr_d     = addr_q;
        pe_valid_d = push;
        pe_first_d = push && (addr_q == top_addr);
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d     = num_steps;
                    state_d = ST_INIT_REQ;
                end
            end
            ST_INIT_REQ: begin
                state_d = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                if (init_done) begin
                    addr_d  = '0;
                    state_d = ST_LEAF;
                end
            end
            ST_LEAF: begin
                if (addr_q == leaf_last) begin
                    // (N-1+1)>>5 == N>>5: first read is the last leaf word
                    s_d     = n_q - STEP_W'(1);
                    addr_d  = leaf_last;
                    state_d = ST_STEP;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_STEP: begin
                if (addr_q == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q - ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    if (s_q == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        s_d     = s_q - STEP_W'(1);
                        addr_d  = last_wr;
                        state_d = ST_STEP;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            s_q        <= '0;
            addr_q     <= '0;
            pe_valid_q <= 1'b0;
            pe_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            s_q        <= s_d;
            addr_q     <= addr_d;
            pe_valid_q <= pe_valid_d;
            pe_first_q <= pe_first_d;
        end
    end

    assign init_start = (state_q == ST_INIT_REQ);
    assign leaf_phase = (state_q == ST_LEAF);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FIN);
    assign rdaddr     = push ? addr_q : '0;
    // Leaf writes and write-backs never overlap: the pipe is empty in LEAF.
    assign wren       = leaf_phase | (out_valid & out_keep);
    assign wraddr     = leaf_phase ? addr_q : out_addr;
    assign pe_valid   = pe_valid_q;
    assign pe_first   = pe_first_q;
    assign step_idx   = s_q;

endmodule

// File: tb/tb_value_membank_ctrl.sv
// Randomised bench for value_membank_ctrl against a cycle-schedule model.
// The model derives every event cycle from N, the init delay and PIPE_LAT.
module tb_value_membank_ctrl;

    localparam int AW   = 11;
    localparam int SW   = 15;
    localparam int P    = 8;
    localparam int MAXC = 8192;

    logic          clk = 1'b0;
    logic          nrst;
    logic          start;
    logic [SW-1:0] num_steps;
    logic          init_start;
    logic          init_done;
    logic [AW-1:0] rdaddr;
    logic [AW-1:0] wraddr;
    logic          wren;
    logic          leaf_phase;
    logic          pe_valid;
    logic          pe_first;
    logic [SW-1:0] step_idx;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit e_init  [MAXC];
    bit e_leaf  [MAXC];
    bit e_wren  [MAXC];
    bit e_rd    [MAXC];
    bit e_pev   [MAXC];
    bit e_first [MAXC];
    bit e_done  [MAXC];
    bit e_busy  [MAXC];
    int e_wa    [MAXC];
    int e_ra    [MAXC];
    int e_st    [MAXC];
    int done_c;
    int first_step_c;

    value_membank_ctrl #(
        .ADDR_W   (AW),
        .STEP_W   (SW),
        .PIPE_LAT (P)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .num_steps  (num_steps),
        .init_start (init_start),
        .init_done  (init_done),
        .rdaddr     (rdaddr),
        .wraddr     (wraddr),
        .wren       (wren),
        .leaf_phase (leaf_phase),
        .pe_valid   (pe_valid),
        .pe_first   (pe_first),
        .step_idx   (step_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({init_start, rdaddr, wraddr, wren, leaf_phase,
                    pe_valid, pe_first, step_idx, busy, done});
    endfunction

    // Expected schedule: init_start at 1, init_done at 1+d, N>>5+1 leaf
    // writes, then per step ((s+1)>>5)+1 descending reads followed by
    // PIPE_LAT drain cycles; writes only for addr <= s>>5.
    function automatic int build(input int n, input int d);
        int c, top, r, a;
        for (int i = 0; i < MAXC; i++) begin
            e_init[i] = 0; e_leaf[i] = 0; e_wren[i] = 0; e_rd[i] = 0;
            e_pev[i] = 0; e_first[i] = 0; e_done[i] = 0; e_busy[i] = 0;
            e_wa[i] = 0; e_ra[i] = 0; e_st[i] = 0;
        end
        e_init[1] = 1;
        for (int i = 0; i <= (n >> 5); i++) begin
            c = d + 2 + i;
            e_leaf[c] = 1;
            e_wren[c] = 1;
            e_wa[c]   = i;
        end
        c = d + 3 + (n >> 5);
        first_step_c = c;
        for (int s = n - 1; s >= 0; s--) begin
            top = (s + 1) / 32;
            r   = top + 1;
            for (int k = 0; k < r; k++) begin
                a = top - k;
                e_rd[c+k]  = 1;
                e_ra[c+k]  = a;
                e_st[c+k]  = s;
                e_pev[c+k+1] = 1;
                if (k == 0) e_first[c+1] = 1;
                if (a <= s / 32) begin
                    e_wren[c+k+P] = 1;
                    e_wa[c+k+P]   = a;
                end
            end
            c = c + r + P;
        end
        e_done[c] = 1;
        for (int i = 1; i <= c; i++) e_busy[i] = 1;
        return c;
    endfunction

    task automatic check_cycle(input int k);
        chk("ctl", 64'({init_start, leaf_phase, wren, pe_valid, pe_first, done}),
            64'({e_init[k], e_leaf[k], e_wren[k], e_pev[k], e_first[k], e_done[k]}));
        if (k != done_c) chk("busy", 64'(busy), 64'(e_busy[k]));
        if (e_wren[k]) chk("wraddr", 64'(wraddr), 64'(e_wa[k]));
        if (e_rd[k]) begin
            chk("rdaddr", 64'(rdaddr), 64'(e_ra[k]));
            chk("step_idx", 64'(step_idx), 64'(e_st[k]));
        end
        if (e_leaf[k]) chk("leaf_rdaddr", 64'(rdaddr), 64'(0));
    endtask

    task automatic run(input int n, input int d, input bit noise, input bit do_rst);
        int nz, rst_at;
        done_c = build(n, d);
        nz     = noise ? int'($urandom_range(done_c - 1, first_step_c)) : -1;
        rst_at = do_rst ? first_step_c + 3 : -1;
        for (int k = 0; k <= done_c + 2; k++) begin
            @(negedge clk);
            cyc = k;
            if (k == rst_at) begin
                nrst = 1'b0;
                start = 1'b0;
                init_done = 1'b0;
                #1;
                chk("rst_async", all_outs(), 64'(0));
                @(negedge clk);
                chk("rst_hold", all_outs(), 64'(0));
                nrst = 1'b1;
                return;
            end
            check_cycle(k);
            start     = (k == 0) || (k == nz);
            num_steps = (k == 0) ? SW'(n) : SW'($urandom);
            init_done = (k == 1 + d) || (k == nz);
        end
        start     = 1'b0;
        init_done = 1'b0;
    endtask

    initial begin
        nrst      = 1'b0;
        start     = 1'b0;
        init_done = 1'b0;
        num_steps = '0;
        repeat (3) @(negedge clk);
        chk("reset", all_outs(), 64'(0));
        nrst = 1'b1;
        run(1, 5, 1'b0, 1'b0);
        run(32, 3, 1'b0, 1'b0);
        run(64, 2, 1'b1, 1'b0);
        // stray init_done while idle must not satisfy the next run's wait
        @(negedge clk);
        init_done = 1'b1;
        @(negedge clk);
        init_done = 1'b0;
        chk("idle_initdone", all_outs(), 64'(0));
        run(33, 4, 1'b0, 1'b0);
        run(40, 2, 1'b0, 1'b1);
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_idle", all_outs(), 64'(0));
        end
        run(40, 1, 1'b0, 1'b0);
        repeat (6) begin
            run(int'($urandom_range(150, 1)), int'($urandom_range(6, 1)),
                1'($urandom_range(1, 0)), 1'b0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/value_membank_ctrl.md
# value_membank_ctrl

Sequencer for the 32-column value memory bank in the American-put lattice engine. It starts and waits out bank zero-initialisation, then writes the leaf words. It then walks the binomial tree backward from step N-1 to step 0, issuing one read per cycle and the delayed write-backs. It sits between the top-level run control and the value bank plus the 32-lane processing-element (PE) array. It owns all bank addressing and write enables.

## Interface
Parameters:
- ADDR_W, 11: bank address width.
- STEP_W, 15: width of step counters; N ≤ 32767 gives at most 1024 words.
- PIPE_LAT, 8: cycles from a read issue to its write-back (1 RAM cycle plus PE depth). Must be ≥ 2.

Ports:
- clk  in  1  Sole clock, rising edge.
- nrst  in  1  Reset, asynchronous assert, active-low. All state and outputs clear immediately.
- start  in  1  One-cycle pulse that begins a run. Ignored while busy.
- num_steps  in  STEP_W  Tree depth N, valid range 1..32767. Sampled on start.
- init_start  out  1  One-cycle pulse to the bank's start_init.
- init_done  in  1  One-cycle pulse from the bank's done_init.
- rdaddr  out  ADDR_W  Bank read address.
- wraddr  out  ADDR_W  Bank write address.
- wren  out  1  Bank write enable.
- leaf_phase  out  1  High during leaf writes. Selects the leaf data source at the bank input.
- pe_valid  out  1  Bank q is valid for the PE this cycle.
- pe_first  out  1  With pe_valid, marks the first (top) word of a step. The PE has no upper neighbour for this word.
- step_idx  out  STEP_W  Current step s, used by the PE for the exercise value.
- busy  out  1  High from start until done.
- done  out  1  One-cycle pulse. The price is in bank address 0, lane 0.

Reset values: every output is 0; the state is IDLE.

## Operation
- States: IDLE, INIT_REQ, INIT_WAIT, LEAF, STEP, DRAIN, FIN.
- IDLE → INIT_REQ on start. Latch N, set busy.
- INIT_REQ: assert init_start for 1 cycle → INIT_WAIT.
- INIT_WAIT: hold until init_done → LEAF.
- LEAF: write addresses 0 up to N>>5, one per cycle, with wren=1 and leaf_phase=1 → STEP with s = N-1.
- STEP(s): issue reads with rdaddr descending from (s+1)>>5 to 0, one per cycle. step_idx = s.
  - Each read a enters the delay pipe tagged keep = (a ≤ s>>5).
  - The top read exists only to supply the lane-0 neighbour when the word count shrinks.
  - After the read of address 0 → DRAIN.
- DRAIN: stay until the pipe is empty.
  - If s = 0 → FIN.
  - Otherwise s ← s-1 → STEP.
- FIN: pulse done for 1 cycle, clear busy → IDLE.
- Write-back: when a pipe entry exits with keep=1, drive wren=1 and wraddr = the tagged address. keep=0 entries are dropped.
- In-place writes are safe: within a step, each address is read once, and its write follows all reads that depend on it.
- Step arithmetic is unsigned: words read = ((s+1)>>5)+1 and words written = (s>>5)+1, using STEP_W-bit internal sums.
- start or init_done while in any other state is ignored.
- Asynchronous reset mid-run: return to IDLE, flush the pipe, drop wren that cycle. The bank contents become undefined. A new start re-initialises the bank.

## Timing
- start at cycle 0 → init_start high at cycle 1.
- First leaf wren is the cycle after init_done.
- A read issued at cycle c (rdaddr valid at c):
  - pe_valid = 1 at c+1;
  - pe_first = 1 at c+1 for the step's first read;
  - wren at c+PIPE_LAT if keep=1.
- Between steps, the first read of step s-1 is issued the cycle after the last write of step s. The pipe must be empty; there is no overlap.
- Cycles per step = ((s+1)>>5)+1 + PIPE_LAT.
- wren is never asserted in STEP and LEAF simultaneously.
- During LEAF, rdaddr holds 0 and pe_valid stays 0.
- done is asserted the cycle after the final write of step 0.

## Structure
- Package value_ctrl_pkg holds:
  - the state enum;
  - ADDR_W and STEP_W defaults;
  - the LANES = 32 constant;
  - the shift LOG2_LANES = 5.
- One sub-module, value_ctrl_pipe: a PIPE_LAT-deep shift register of {valid, keep, addr}, with async clear. It provides an empty flag and an exit port.
- The FSM, step counter and address counter live in the top module.

## Test plan
- N=1, PIPE_LAT=8, init_done 5 cycles after init_start:
  - 1 leaf write at addr 0;
  - step 0 reads addr 0 and writes addr 0 8 cycles later;
  - done on the next cycle; busy falls with done.
- N=32 (word-shrink boundary):
  - leaf writes addr 0,1;
  - step 31 reads 1 then 0 and writes only addr 0 (addr 1 dropped);
  - step 30 reads only addr 0;
  - 32 steps in total before done.
- N=64:
  - step 63 reads 2,1,0 and writes 1,0;
  - pe_first is high on the addr 2 data cycle only.
- start pulsed during STEP: no effect on addresses, step_idx or done count.
- Reset asserted mid-DRAIN with a write pending: all outputs 0 immediately, no wren, state IDLE. A subsequent start reruns from INIT_REQ.
- init_done pulsed while IDLE, then start: the FSM still waits for a fresh init_done before LEAF.
